i2c_rx_sequencer: RTL and testbench
===================================

Name: i2c_rx_sequencer

Overview:
- Byte-receive controller for the I2C target path.
- Sits on the issuing side of the shared 8-bit ALU: it drives the opcode and operands, then consumes the result and flag.
- Uses ALU op 2 (shift-in) to assemble each byte from SDA and ALU op 1 (subtract, not-equal flag) to count bits.
- Detects START/STOP, samples SDA on SCL rising edges, optionally ACKs, and hands each byte to the core over a valid/ready handshake.

Parameters:
SYNC_STAGES, 2, flip-flop stages on scl_i/sda_i before edge detection (minimum 2)
BIT_COUNT, 8, bits per byte; counter load value (1..8)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
scl_i  in  1  raw SCL line
sda_i  in  1  raw SDA line
sda_oe  out  1  1 = pull SDA low (open-drain enable)
alu_s  out  2  ALU opcode
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_c  in  8  ALU result (combinational, same cycle)
alu_z  in  1  ALU flag (combinational, same cycle)
rx_data  out  8  received byte
rx_valid  out  1  byte available; held until accepted
rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready
busy  out  1  1 while inside a START..STOP transaction
ovf  out  1  sticky overrun flag; cleared only by reset

Behaviour:
- One clock. Reset is synchronous and active-low (rst_n sampled on clk rising edge). Clock/reset names: clk, rst_n.
- Reset values: sda_oe=0, alu_s=0, alu_a=0, alu_b=0, rx_data=0, rx_valid=0, busy=0, ovf=0, shift reg=0, bit counter=BIT_COUNT, state=IDLE.
- Synchronizer: scl_i/sda_i pass through SYNC_STAGES flops, then one history flop. Edges come from synced vs history.
  - rise/fall = SCL edge.
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
- ALU drive:
  - Registered outputs, so the ALU sees them one cycle after the decision.
  - The result is captured on the following clk edge.
  - Idle drive: alu_s=0, a=0, b=0.
- States:
  - IDLE: wait START -> WAIT_RISE; busy=1, shreg=0, cnt=BIT_COUNT.
  - WAIT_RISE: on SCL rise -> SHIFT_ISSUE, latching the synced SDA bit.
  - SHIFT_ISSUE: drive alu_s=2, alu_a={7'b0,bit}, alu_b=shreg -> SHIFT_CAP.
  - SHIFT_CAP: shreg<=alu_c; then drive alu_s=1, alu_a=1, alu_b=cnt -> CNT_CAP.
  - CNT_CAP: cnt<=alu_c.
    - alu_z=1 (cnt!=1): -> WAIT_RISE.
    - alu_z=0 (last bit): -> BYTE_DONE.
  - BYTE_DONE:
    - If rx_valid=0: rx_data<=shreg, rx_valid<=1.
    - Else: ovf<=1 and the byte is dropped.
    - Then -> ACK_FALL.
  - ACK_FALL: wait SCL fall -> ACK_HOLD (sda_oe per optional feature).
  - ACK_HOLD: wait SCL fall (end of 9th clock) -> sda_oe=0, shreg=0, cnt=BIT_COUNT, -> WAIT_RISE.
- Handshake:
  - rx_valid clears on the cycle after rx_valid&rx_ready.
  - If a new byte completes in the same cycle as acceptance, the new byte loads and rx_valid stays 1, with no ovf.
- STOP in any non-IDLE state -> IDLE, busy=0, sda_oe=0. A partial byte is discarded with no rx_valid.
- START in any non-IDLE state (repeated start): reload shreg/cnt -> WAIT_RISE, busy stays 1.
- START/STOP takes priority over SCL edges in the same cycle.
- SCL rise while in SHIFT_ISSUE/SHIFT_CAP/CNT_CAP is a protocol violation (SCL too fast): ignore it. Minimum SCL high+low is 4 clk plus synchronizer latency.
- Bit order: MSB first (first bit lands in rx_data[7] for BIT_COUNT=8).

Optional Feature:
- Macro I2C_RX_SEQUENCER_ACK_EN.
- Defined:
  - In ACK_HOLD, sda_oe=1 (ACK) if the byte was stored.
  - sda_oe=0 (NACK) if it was dropped due to overrun.
- Undefined: sda_oe is tied 0 and the block only observes the bus. The ACK_FALL/ACK_HOLD timing is unchanged.

Decomposition:
- Shared package i2c_pkg holds:
  - ALU opcode constants: ALU_PASS=2'h0, ALU_SUB=2'h1, ALU_SHL_IN=2'h2, ALU_AND=2'h3.
  - The state enum for this block.
  - BYTE_W=8.
- One natural sub-module: i2c_line_sync (synchronizer + edge/START/STOP detect, parameter SYNC_STAGES). The same sub-module can be reused by the transmitter.

Test Plan:
- START, bits 1,0,1,0,0,1,0,1, STOP with rx_ready=1 -> rx_data=8'hA5, one rx_valid pulse, busy 1->0, alu_s sequence 2,1 repeated 8 times.
- Two bytes 8'h3C then 8'hFF with rx_ready=0 -> rx_data holds 8'h3C, ovf=1. With ACK_EN: 9th clock ACKs byte 1 (sda_oe=1) and NACKs byte 2.
- STOP after 5 bits -> IDLE, rx_valid never asserts, sda_oe=0, cnt reloads to 8.
- Repeated START after 3 bits, then 8 bits of 8'h81 -> rx_data=8'h81 (no stale bits).
- rst_n=0 for 1 clk mid-byte -> all outputs at reset values the next cycle; the next START/byte 8'h5A receives correctly.
- Acceptance and byte completion in the same cycle -> rx_valid stays 1, rx_data updates, ovf=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: ALU opcodes, byte width and the receive sequencer state set.
package i2c_pkg;
  localparam int BYTE_W = 8;

  localparam logic [1:0] ALU_PASS   = 2'h0;
  localparam logic [1:0] ALU_SUB    = 2'h1;
  localparam logic [1:0] ALU_SHL_IN = 2'h2;
  localparam logic [1:0] ALU_AND    = 2'h3;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_RISE   = 3'd1,
    ST_SHIFT_ISSUE = 3'd2,
    ST_SHIFT_CAP   = 3'd3,
    ST_CNT_CAP     = 3'd4,
    ST_BYTE_DONE   = 3'd5,
    ST_ACK_FALL    = 3'd6,
    ST_ACK_HOLD    = 3'd7
  } rx_state_e;
endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with SCL edge and START/STOP detection.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s;

  // Reset to the idle-bus level so leaving reset never fakes an edge on a quiet bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_hist_q;
  assign scl_fall_o = ~scl_s & scl_hist_q;
  assign start_o    = scl_s & sda_hist_q & ~sda_s;
  assign stop_o     = scl_s & ~sda_hist_q & sda_s;
endmodule

// File: rtl/i2c_rx_sequencer.sv
// I2C target byte receiver driving the shared ALU for shift-in and bit counting.
// Define I2C_RX_SEQUENCER_ACK_EN to ACK stored bytes on the 9th clock; otherwise observe only.
module i2c_rx_sequencer
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BIT_COUNT   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [1:0]        alu_s,
  output logic [BYTE_W-1:0] alu_a,
  output logic [BYTE_W-1:0] alu_b,
  input  logic [BYTE_W-1:0] alu_c,
  input  logic              alu_z,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              ovf
);
  localparam logic [BYTE_W-1:0] CNT_LOAD = BYTE_W'(BIT_COUNT);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  rx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] shreg_q, shreg_d, cnt_q, cnt_d;
  logic              bit_q, bit_d;
  logic [1:0]        alu_s_q, alu_s_d;
  logic [BYTE_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              busy_q, busy_d, ovf_q, ovf_d;
`ifdef I2C_RX_SEQUENCER_ACK_EN
  logic              sda_oe_q, sda_oe_d, stored_q, stored_d;
`endif

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    alu_s_d    = ALU_PASS;
    alu_a_d    = '0;
    alu_b_d    = '0;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
`ifdef I2C_RX_SEQUENCER_ACK_EN
    sda_oe_d   = sda_oe_q;
    stored_d   = stored_q;
`endif
    // Bus conditions override any SCL edge seen in the same cycle.
    if (stop_det && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
`ifdef I2C_RX_SEQUENCER_ACK_EN
      sda_oe_d = 1'b0;
`endif
    end else if (start_det) begin
      state_d = ST_WAIT_RISE;
      busy_d  = 1'b1;
      shreg_d = '0;
      cnt_d   = CNT_LOAD;
`ifdef I2C_RX_SEQUENCER_ACK_EN
      sda_oe_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_WAIT_RISE: if (scl_rise) begin
          bit_d   = sda_s;
          state_d = ST_SHIFT_ISSUE;
        end
        ST_SHIFT_ISSUE: begin
          alu_s_d = ALU_SHL_IN;
          alu_a_d = {{(BYTE_W-1){1'b0}}, bit_q};
          alu_b_d = shreg_q;
          state_d = ST_SHIFT_CAP;
        end
        ST_SHIFT_CAP: begin
          shreg_d = alu_c;
          alu_s_d = ALU_SUB;
          alu_a_d = BYTE_W'(1);
          alu_b_d = cnt_q;
          state_d = ST_CNT_CAP;
        end
        ST_CNT_CAP: begin
          cnt_d   = alu_c;
          state_d = alu_z ? ST_WAIT_RISE : ST_BYTE_DONE;
        end
        ST_BYTE_DONE: begin
          // A slot being accepted this cycle counts as free.
          if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
`ifdef I2C_RX_SEQUENCER_ACK_EN
          stored_d = !rx_valid_q || rx_ready;
`endif
          state_d = ST_ACK_FALL;
        end
        ST_ACK_FALL: if (scl_fall) begin
`ifdef I2C_RX_SEQUENCER_ACK_EN
          sda_oe_d = stored_q;
`endif
          state_d = ST_ACK_HOLD;
        end
        ST_ACK_HOLD: if (scl_fall) begin
`ifdef I2C_RX_SEQUENCER_ACK_EN
          sda_oe_d = 1'b0;
`endif
          shreg_d = '0;
          cnt_d   = CNT_LOAD;
          state_d = ST_WAIT_RISE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= CNT_LOAD;
      bit_q      <= 1'b0;
      alu_s_q    <= ALU_PASS;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
`ifdef I2C_RX_SEQUENCER_ACK_EN
      sda_oe_q   <= 1'b0;
      stored_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      alu_s_q    <= alu_s_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
`ifdef I2C_RX_SEQUENCER_ACK_EN
      sda_oe_q   <= sda_oe_d;
      stored_q   <= stored_d;
`endif
    end
  end

`ifdef I2C_RX_SEQUENCER_ACK_EN
  assign sda_oe = sda_oe_q;
`else
  assign sda_oe = 1'b0;
`endif
  assign alu_s    = alu_s_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;
endmodule

// File: tb/tb_i2c_rx_sequencer.sv
// Bench for i2c_rx_sequencer: bus-level I2C master, ALU model and byte scoreboard.
module tb_i2c_rx_sequencer;
`ifdef I2C_RX_SEQUENCER_ACK_EN
  localparam logic ACKX = 1'b1;
`else
  localparam logic ACKX = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, scl_i = 1'b1, sda_i = 1'b1, rx_ready = 1'b0;
  logic       sda_oe, alu_z, rx_valid, busy, ovf;
  logic [1:0] alu_s;
  logic [7:0] alu_a, alu_b, alu_c, rx_data;

  int checks = 0, errors = 0;
  int h = 8;
  logic [7:0] expq[$];
  logic [7:0] opb[$];
  int         n_shl[$];

  always #5 clk = ~clk;

  // Shared ALU: op0 pass, op1 b-a, op2 shift-in a[0] at LSB, op3 and; flag = result nonzero.
  always_comb begin
    case (alu_s)
      2'd0:    alu_c = alu_a;
      2'd1:    alu_c = alu_b - alu_a;
      2'd2:    alu_c = {alu_b[6:0], alu_a[0]};
      default: alu_c = alu_a & alu_b;
    endcase
    alu_z = (alu_c != 8'd0);
  end

  i2c_rx_sequencer #(.SYNC_STAGES(2), .BIT_COUNT(8)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_z(alu_z),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .busy(busy), .ovf(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Per-cycle monitor: byte scoreboard, ALU issue order, observe-only SDA, sticky ovf.
  logic       pv = 1'b0, phs = 1'b0, ovf_seen = 1'b0;
  logic [1:0] ps = 2'd0;
  logic [7:0] last_rx = 8'h00;
  int         npres = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && (!pv || phs)) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_byte got %0h want none", rx_data);
        end else chk("rx_data", rx_data, expq[0]);
        last_rx <= rx_data;
        npres   <= npres + 1;
      end
      if (rx_valid && rx_ready && expq.size() > 0) void'(expq.pop_front());
      if (alu_s == 2'd1) begin
        chk("sub_after_shl", ps, 2'd2);
        chk("sub_a", alu_a, 8'd1);
        opb.push_back(alu_b);
      end
      if (alu_s == 2'd2) begin
        chk("shl_a", alu_a[7:1], 7'd0);
        n_shl.push_back(1);
      end
`ifndef I2C_RX_SEQUENCER_ACK_EN
      chk("sda_oe_idle", sda_oe, 1'b0);
`endif
      if (ovf_seen) chk("ovf_sticky", ovf, 1'b1);
      ovf_seen <= ovf_seen | ovf;
    end else ovf_seen <= 1'b0;
    pv  <= rx_valid;
    phs <= rx_valid & rx_ready;
    ps  <= alu_s;
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    clk_n(2); sda_i = b; clk_n(h); scl_i = 1'b1; clk_n(h); scl_i = 1'b0;
  endtask

  task automatic do_start();
    if (!scl_i) begin
      clk_n(2); sda_i = 1'b1; clk_n(h); scl_i = 1'b1; clk_n(h);
    end
    sda_i = 1'b0; clk_n(h); scl_i = 1'b0;
  endtask

  task automatic do_stop();
    clk_n(2); sda_i = 1'b0; clk_n(h); scl_i = 1'b1; clk_n(h); sda_i = 1'b1; clk_n(h);
  endtask

  // Eight data bits MSB first, then the 9th clock with SDA released; samples sda_oe mid-high.
  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    clk_n(2); sda_i = 1'b1; clk_n(h); scl_i = 1'b1;
    clk_n(h / 2); ack = sda_oe; clk_n(h - h / 2); scl_i = 1'b0;
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         nb, np0;

    clk_n(3);
    chk("rst_sda_oe", sda_oe, 1'b0);  chk("rst_alu_s", alu_s, 2'd0);
    chk("rst_alu_a", alu_a, 8'd0);    chk("rst_alu_b", alu_b, 8'd0);
    chk("rst_rx_data", rx_data, 8'd0); chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);      chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1; clk_n(4);

    // Single byte A5 with ALU issue trace
    rx_ready = 1'b1;
    do_start(); clk_n(4);
    chk("busy_after_start", busy, 1'b1);
    opb.delete(); n_shl.delete();
    expq.push_back(8'hA5);
    send_byte(8'hA5, ack);
    chk("ack_a5", ack, ACKX);
    chk("shl_count", n_shl.size(), 8);
    chk("sub_count", opb.size(), 8);
    for (int i = 0; i < 8 && i < opb.size(); i++) chk("sub_b_seq", opb[i], 8 - i);
    chk("lit_a5", last_rx, 8'hA5);
    chk("one_pulse", npres, 1);
    do_stop(); clk_n(6);
    chk("busy_after_stop", busy, 1'b0);

    // Random multi-byte transactions, consumer always ready
    for (int t = 0; t < 6; t++) begin
      h = $urandom_range(7, 12);
      do_start();
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        d = 8'($urandom);
        expq.push_back(d);
        send_byte(d, ack);
        chk("ack_rand", ack, ACKX);
      end
      do_stop(); clk_n(8);
      chk("rand_drained", expq.size(), 0);
    end
    h = 8;

    // Acceptance of byte 1 in the same cycle byte 2 completes
    rx_ready = 1'b0;
    do_start();
    expq.push_back(8'h11);
    send_byte(8'h11, ack);
    expq.push_back(8'h22);
    fork
      send_byte(8'h22, ack);
      begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
          @(negedge clk);
          if (alu_s == 2'd1 && alu_b == 8'd1) hit = 1'b1;
        end
        if (!hit) begin
          checks++; errors++;
          $display("FAIL last_bit_timeout got none want sub_b=1");
        end else begin
          @(posedge clk); #1 rx_ready = 1'b1;
          @(posedge clk); #1 rx_ready = 1'b0;
          chk("same_cycle_valid", rx_valid, 1'b1);
          chk("same_cycle_data", rx_data, 8'h22);
          chk("same_cycle_ovf", ovf, 1'b0);
        end
      end
    join
    rx_ready = 1'b1;
    do_stop(); clk_n(6);
    chk("same_cycle_drained", expq.size(), 0);

    // Repeated START after 3 bits
    do_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    do_start();
    expq.push_back(8'h81);
    send_byte(8'h81, ack);
    do_stop(); clk_n(6);
    chk("lit_81", last_rx, 8'h81);

    // STOP after 5 bits, then a full byte
    np0 = npres;
    do_start();
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    do_stop(); clk_n(10);
    chk("partial_no_valid", npres, np0);
    chk("partial_busy", busy, 1'b0);
    chk("partial_sda_oe", sda_oe, 1'b0);
    do_start();
    expq.push_back(8'hC3);
    send_byte(8'hC3, ack);
    do_stop(); clk_n(6);
    chk("lit_c3", last_rx, 8'hC3);

    // Overrun: consumer stalled across two bytes
    rx_ready = 1'b0;
    do_start();
    expq.push_back(8'h3C);
    send_byte(8'h3C, ack);
    chk("ack_byte1", ack, ACKX);
    send_byte(8'hFF, ack);
    chk("nack_byte2", ack, 1'b0);
    do_stop(); clk_n(6);
    chk("ovf_data", rx_data, 8'h3C);
    chk("ovf_valid", rx_valid, 1'b1);
    chk("ovf_set", ovf, 1'b1);
    rx_ready = 1'b1; clk_n(3);
    chk("ovf_drain_valid", rx_valid, 1'b0);
    chk("ovf_still", ovf, 1'b1);

    // Reset pulse mid-byte, then a fresh byte
    do_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0; clk_n(1);
    chk("mid_rst_sda_oe", sda_oe, 1'b0); chk("mid_rst_alu_s", alu_s, 2'd0);
    chk("mid_rst_alu_a", alu_a, 8'd0);   chk("mid_rst_alu_b", alu_b, 8'd0);
    chk("mid_rst_rx_data", rx_data, 8'd0); chk("mid_rst_rx_valid", rx_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);     chk("mid_rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    do_stop(); clk_n(4);
    do_start();
    expq.push_back(8'h5A);
    send_byte(8'h5A, ack);
    chk("ack_5a", ack, ACKX);
    do_stop(); clk_n(6);
    chk("lit_5a", last_rx, 8'h5A);
    chk("ovf_after_rst", ovf, 1'b0);
    chk("final_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
